sr_fetch_queue: RTL and testbench

// Instruction fetch stage upstream of the sr_cpu decode. Owns the fetch PC, issues word

---
 rtl/sr_fetch_queue.sv | 110 +++++++++++
 tb/tb_sr_fetch_queue.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_fetch_queue.sv
// rtl/sr_fetch_queue.sv - instruction fetch stage with credit-limited request issue and a small return FIFO
module sr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imReq,
    output logic [31:0]              imAddr,
    input  logic [31:0]              imData,
    input  logic                     redirect,
    input  logic [31:0]              redirectPc,
    output logic                     outValid,
    output logic [31:0]              outInstr,
    output logic [31:0]              outPc,
    input  logic                     outReady,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          inflight_q, inflight_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_pc_q, req_pc_d;

    logic [31:0]   instr_mem_q [DEPTH];
    logic [31:0]   pc_mem_q    [DEPTH];

    logic [CW:0]   credit_used;
    logic          push;
    logic          pop;
    logic          unused_bits;

    // The low two bits of a redirect target are forced to zero, so they are never read.
    assign unused_bits = &{1'b0, redirectPc[1:0]};

    // A request may only go out when every buffered word plus the one in flight still fits,
    // so a response always has a free slot when it lands.
    assign credit_used = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    assign imReq       = !rst && !redirect && (credit_used < DEPTH_W);
    assign imAddr      = {2'b00, fetch_pc_q[31:2]};

    // A redirect discards the returning word and freezes the consumer side for that cycle.
    assign push = inflight_q && !redirect;
    assign pop  = outValid && outReady && !redirect;

    assign outValid  = (count_q != '0);
    assign outInstr  = outValid ? instr_mem_q[rd_ptr_q] : 32'h0;
    assign outPc     = outValid ? pc_mem_q[rd_ptr_q]    : 32'h0;
    assign occupancy = count_q;

    // Next-state for pointers, count, in-flight flag and fetch PC; redirect has top priority.
    always_comb begin
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        inflight_d = inflight_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        if (redirect) begin
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            inflight_d = 1'b0;
            fetch_pc_d = {redirectPc[31:2], 2'b00};
        end else begin
            wr_ptr_d   = wr_ptr_q + PW'(push);
            rd_ptr_d   = rd_ptr_q + PW'(pop);
            count_d    = count_q + CW'(push) - CW'(pop);
            inflight_d = imReq;
            if (imReq) begin
                req_pc_d   = fetch_pc_q;
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            inflight_q <= 1'b0;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
        end else begin
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            inflight_q <= inflight_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
        end
    end

    // FIFO storage: the returning word is written at the tail together with its request PC.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            instr_mem_q[wr_ptr_q] <= imData;
            pc_mem_q[wr_ptr_q]    <= req_pc_q;
        end
    end

endmodule

// File: tb/tb_sr_fetch_queue.sv
// tb/tb_sr_fetch_queue.sv - randomized and directed bench for sr_fetch_queue against a queue model
module tb_sr_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic        imReq;
    logic [31:0] imAddr;
    logic [31:0] imData;
    logic        redirect;
    logic [31:0] redirectPc;
    logic        outValid;
    logic [31:0] outInstr;
    logic [31:0] outPc;
    logic        outReady;
    logic [$clog2(DEPTH):0] occupancy;

    sr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .rst        (rst),
        .imReq      (imReq),
        .imAddr     (imAddr),
        .imData     (imData),
        .redirect   (redirect),
        .redirectPc (redirectPc),
        .outValid   (outValid),
        .outInstr   (outInstr),
        .outPc      (outPc),
        .outReady   (outReady),
        .occupancy  (occupancy)
    );

    always #5 clk = ~clk;

    // Instruction memory contents as a pure function of word address.
    bit hash_en = 1'b0;
    function automatic logic [31:0] memf(input logic [31:0] a);
        if (hash_en) return (a * 32'h9E3779B1) ^ 32'h5A5A_0000;
        return a;
    endfunction

    // Synchronous-read memory: one cycle latency.
    always @(posedge clk) begin
        if (imReq) imData <= memf(imAddr);
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t      mq[$];
    logic [31:0] m_fetch;
    logic [31:0] m_pend_pc;
    bit          m_pend;
    bit          mon = 1'b0;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit model_req();
        return !rst && !redirect && ((mq.size() + int'(m_pend)) < DEPTH);
    endfunction

    // Compare all outputs against the model, away from the active edge.
    task automatic sample();
        #1;
        if (mon) begin
            chk("imReq", {31'b0, imReq}, {31'b0, model_req()});
            chk("imAddr", imAddr, {2'b00, m_fetch[31:2]});
            chk("occupancy", 32'(occupancy), 32'(mq.size()));
            chk("outValid", {31'b0, outValid}, {31'b0, mq.size() != 0});
            if (mq.size() != 0) begin
                chk("outPc", outPc, mq[0].pc);
                chk("outInstr", outInstr, mq[0].instr);
            end
        end
    endtask

    // Advance one clock and apply the architectural rules to the model.
    task automatic tick();
        bit req;
        @(posedge clk);
        req = model_req();
        if (rst) begin
            mq.delete();
            m_pend  = 1'b0;
            m_fetch = RESET_PC;
            mon     = 1'b1;
        end else if (redirect) begin
            mq.delete();
            m_pend  = 1'b0;
            m_fetch = {redirectPc[31:2], 2'b00};
        end else begin
            if (mq.size() != 0 && outReady) void'(mq.pop_front());
            if (m_pend) mq.push_back('{pc: m_pend_pc, instr: memf({2'b00, m_pend_pc[31:2]})});
            m_pend = req;
            if (req) begin
                m_pend_pc = m_fetch;
                m_fetch   = m_fetch + 32'd4;
            end
        end
        @(negedge clk);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            sample();
            tick();
        end
    endtask

    task automatic wait_valid(input string nm);
        int k;
        k = 0;
        while (!outValid && k < 12) begin
            step(1);
            k++;
        end
        chk(nm, {31'b0, outValid}, 32'd1);
    endtask

    initial begin
        rst        = 1'b1;
        redirect   = 1'b0;
        redirectPc = 32'h0;
        outReady   = 1'b0;
        step(3);

        // Reset values and first delivery timing
        sample();
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_outValid", {31'b0, outValid}, 32'd0);
        chk("rst_outPc", outPc, 32'd0);
        chk("rst_outInstr", outInstr, 32'd0);
        chk("rst_imReq", {31'b0, imReq}, 32'd0);
        rst = 1'b0;
        outReady = 1'b1;
        sample();
        chk("c1_imReq", {31'b0, imReq}, 32'd1);
        chk("c1_imAddr", imAddr, 32'd0);
        tick();
        step(1);
        sample();
        chk("c3_outValid", {31'b0, outValid}, 32'd1);
        chk("c3_outPc", outPc, 32'h0);
        chk("c3_outInstr", outInstr, 32'h0);
        tick();
        sample();
        chk("c4_outPc", outPc, 32'h4);
        chk("c4_outInstr", outInstr, 32'h1);
        tick();
        sample();
        chk("c5_outPc", outPc, 32'h8);
        tick();
        step(10);

        // Back-pressure saturates the FIFO
        outReady = 1'b0;
        step(10);
        sample();
        chk("full_occ", 32'(occupancy), 32'd4);
        chk("full_imReq", {31'b0, imReq}, 32'd0);
        outReady = 1'b1;
        step(12);

        // Redirect with three buffered and one in flight
        outReady = 1'b1;
        redirect = 1'b1;
        redirectPc = 32'h200;
        step(1);
        redirect = 1'b0;
        outReady = 1'b0;
        for (int k = 0; k < 10 && !(mq.size() == 3 && m_pend); k++) step(1);
        chk("pre_redirect_occ", 32'(occupancy), 32'd3);
        redirect = 1'b1;
        redirectPc = 32'h103;
        step(1);
        redirect = 1'b0;
        sample();
        chk("redir_occ", 32'(occupancy), 32'd0);
        chk("redir_outValid", {31'b0, outValid}, 32'd0);
        chk("redir_imAddr", imAddr, 32'h40);
        outReady = 1'b1;
        wait_valid("redir_timeout");
        sample();
        chk("redir_outPc", outPc, 32'h100);
        chk("redir_outInstr", outInstr, 32'h40);
        step(6);

        // Redirect coinciding with a pop, then two back-to-back redirects
        sample();
        chk("pop_redir_valid", {31'b0, outValid}, 32'd1);
        redirect = 1'b1;
        redirectPc = 32'h40;
        step(1);
        redirectPc = 32'h80;
        step(1);
        redirect = 1'b0;
        wait_valid("b2b_timeout");
        sample();
        chk("b2b_outPc", outPc, 32'h80);
        step(8);

        // Reset mid-stream with a full FIFO
        outReady = 1'b0;
        step(8);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        sample();
        chk("mrst_occ", 32'(occupancy), 32'd0);
        chk("mrst_outValid", {31'b0, outValid}, 32'd0);
        chk("mrst_outPc", outPc, 32'd0);
        chk("mrst_outInstr", outInstr, 32'd0);
        chk("mrst_imAddr", imAddr, RESET_PC >> 2);
        outReady = 1'b1;
        wait_valid("mrst_timeout");
        sample();
        chk("mrst_outPc2", outPc, RESET_PC);

        // Randomized traffic with redirects, wrap-around targets and occasional reset
        rst = 1'b1;
        step(1);
        hash_en = 1'b1;
        rst = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            int r;
            outReady = 1'($urandom_range(0, 1));
            r = int'($urandom_range(0, 999));
            redirect = (r < 30);
            rst = (r >= 995);
            if ($urandom_range(0, 1) == 1)
                redirectPc = $urandom();
            else
                redirectPc = 32'hFFFF_FFE0 | 32'($urandom_range(0, 31));
            step(1);
        end
        rst = 1'b0;
        redirect = 1'b0;
        outReady = 1'b1;
        step(10);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
